video_colorizer: RTL and testbench
==================================

VIDEO_COLORIZER -- requirements
Module: video_colorizer

Interface
REQ-001 Parameter: SCAN_SHIFT, default 1, right-shift applied to R/G/B on darkened scanlines (1..3).
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ce_pix  in  1  pixel enable from the upstream video generator; all pipeline advance qualified by it.
REQ-005 scandouble  in  1  1 = line-doubled 31 kHz timing; enables scanline darkening.
REQ-006 mode  in  2  colour map select: 0 green mono, 1 amber, 2 grey, 3 cyan.
REQ-007 hblank, hsync, vblank, vsync  in  1 each  upstream timing, active-high.
REQ-008 video  in  8  upstream intensity.
REQ-009 ce_pix_o  out  1  registered copy of ce_pix, one clk late.
REQ-010 hblank_o, hsync_o, vblank_o, vsync_o  out  1 each  timing delayed to match pixel latency.
REQ-011 de_o  out  1  ~(hblank_o | vblank_o).
REQ-012 r_o, g_o, b_o  out  8 each  coloured pixel.
REQ-013 frame_o  out  8  frame counter.

Function
REQ-014 Pipeline SHALL be two stages, each advancing only on a clk where ce_pix=1; latency exactly 2 ce_pix cycles for pixel and timing signals together.
REQ-015 Stage 1 SHALL register video, timing bits, and compute the colour map: mode 0 {0,v,0}; 1 {v,v>>1... computed as (v*3)>>2 truncated to 8 bits, 0} i.e. R=v, G=(3v)>>2, B=0; 2 {v,v,v}; 3 {0,v,v}.
REQ-016 Stage 2 SHALL apply scanline darkening and blank forcing, and drive outputs.
REQ-017 A line parity bit SHALL toggle on each rising edge of hblank (sampled at stage-1 input on ce_pix) and clear to 0 on each rising edge of vblank; a simultaneous rising edge of both SHALL clear.
REQ-018 Darkening SHALL apply when scanline feature enabled, scandouble=1 and parity=1: each channel >> SCAN_SHIFT.
REQ-019 When hblank or vblank (stage-aligned) is 1, r_o/g_o/b_o SHALL be 0.
REQ-020 frame_o SHALL increment by 1 on each vsync rising edge (ce_pix qualified), wrapping 255 -> 0.
REQ-021 mode and scandouble SHALL be sampled at stage 1; a change takes effect on the next ce_pix pixel, never mid-pixel.
REQ-022 ce_pix low for any number of clk SHALL hold all stage contents and outputs except ce_pix_o.

Reset
REQ-023 On reset=1: all outputs 0, parity 0, frame_o 0, pipeline registers 0; reset overrides ce_pix.
REQ-024 Reset mid-line SHALL discard in-flight pixels; first valid output is the second ce_pix after reset deasserts.

Configuration
REQ-025 Macro VIDEO_COLORIZER_SCANLINE_EN: defined -> REQ-017/018 active; undefined -> parity logic omitted, channels never darkened, scandouble ignored; all other behaviour identical.

Structure
REQ-026 Shared package video_pkg SHALL hold the mode encodings (MODE_GREEN=0, MODE_AMBER=1, MODE_GREY=2, MODE_CYAN=3) and the 8-bit pixel type.
REQ-027 Colour mapping SHALL be a sub-module video_palette (combinational, mode+v -> RGB); everything else in video_colorizer.

Verification
REQ-028 mode=0, video=0x80, blanks 0, ce_pix every clk -> after 2 ce_pix, r/g/b = 00/80/00, de_o=1.
REQ-029 mode=1, video=0xFF -> r/g/b = FF/BF/00.
REQ-030 SCANLINE_EN defined, scandouble=1, mode=2, video=0xC8, SCAN_SHIFT=1 -> even lines C8/C8/C8, odd lines 64/64/64; vblank rise resets to even.
REQ-031 hblank=1 with video=0xFF -> r/g/b = 0 and hblank_o=1 exactly 2 ce_pix later; de_o=0.
REQ-032 256 vsync pulses from reset -> frame_o returns to 0; reset asserted mid-line -> all outputs 0 next clk.
REQ-033 ce_pix alternating 1/0 -> outputs change only one clk after a ce_pix=1 clk; latency still 2 ce_pix.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video types: colour-map mode encodings and 8-bit pixel/RGB types.
package video_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    MODE_GREEN = 2'd0,
    MODE_AMBER = 2'd1,
    MODE_GREY  = 2'd2,
    MODE_CYAN  = 2'd3
  } mode_e;

  typedef struct packed {
    pixel_t r;
    pixel_t g;
    pixel_t b;
  } rgb_t;

endpackage

// File: rtl/video_palette.sv
// Combinational colour map: intensity plus mode select to an RGB triple.
module video_palette
  import video_pkg::*;
(
  input  logic [1:0] mode_i,
  input  pixel_t     video_i,
  output rgb_t       rgb_o
);

  logic [9:0] amber_w;

  always_comb begin
    amber_w = ({2'b00, video_i} << 1) + {2'b00, video_i};
    rgb_o   = '0;
    case (mode_e'(mode_i))
      MODE_GREEN: rgb_o = '{r: '0,      g: video_i,       b: '0};
      MODE_AMBER: rgb_o = '{r: video_i, g: amber_w[9:2],  b: '0};
      MODE_GREY:  rgb_o = '{r: video_i, g: video_i,       b: video_i};
      MODE_CYAN:  rgb_o = '{r: '0,      g: video_i,       b: video_i};
      default:    rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/video_colorizer.sv
// Two-stage ce_pix-qualified colourizer with blank forcing and frame counter.
// Optional scanline darkening is built when VIDEO_COLORIZER_SCANLINE_EN is defined.
module video_colorizer
  import video_pkg::*;
#(
  parameter int unsigned SCAN_SHIFT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       scandouble,
  input  logic [1:0] mode,
  input  logic       hblank,
  input  logic       hsync,
  input  logic       vblank,
  input  logic       vsync,
  input  logic [7:0] video,
  output logic       ce_pix_o,
  output logic       hblank_o,
  output logic       hsync_o,
  output logic       vblank_o,
  output logic       vsync_o,
  output logic       de_o,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o,
  output logic [7:0] frame_o
);

  rgb_t   pal_rgb;
  rgb_t   s1_rgb_q;
  logic   s1_hb_q, s1_hs_q, s1_vb_q, s1_vs_q, s1_de_q, s1_dark_q;
  logic   dark_d;

  rgb_t   s2_rgb_q, s2_rgb_d;
  logic   s2_hb_q, s2_hs_q, s2_vb_q, s2_vs_q, s2_de_q;
  logic   ce_q;
  pixel_t frame_q;

  video_palette u_palette (
    .mode_i  (mode),
    .video_i (video),
    .rgb_o   (pal_rgb)
  );

`ifdef VIDEO_COLORIZER_SCANLINE_EN
  logic parity_q, parity_d;

  // Stage-1 timing registers double as the previous-sample edge detectors.
  always_comb begin
    parity_d = parity_q;
    if (vblank && !s1_vb_q)
      parity_d = 1'b0;
    else if (hblank && !s1_hb_q)
      parity_d = ~parity_q;
  end

  always_ff @(posedge clk) begin
    if (reset)
      parity_q <= 1'b0;
    else if (ce_pix)
      parity_q <= parity_d;
  end

  assign dark_d = scandouble & parity_q;
`else
  logic unused_scandouble;
  assign unused_scandouble = scandouble;
  assign dark_d = 1'b0;
`endif

  always_comb begin
    s2_rgb_d = s1_rgb_q;
    if (s1_dark_q) begin
      s2_rgb_d.r = s1_rgb_q.r >> SCAN_SHIFT;
      s2_rgb_d.g = s1_rgb_q.g >> SCAN_SHIFT;
      s2_rgb_d.b = s1_rgb_q.b >> SCAN_SHIFT;
    end
    if (s1_hb_q || s1_vb_q)
      s2_rgb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_q      <= 1'b0;
      s1_rgb_q  <= '0;
      s1_hb_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vb_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_dark_q <= 1'b0;
      s2_rgb_q  <= '0;
      s2_hb_q   <= 1'b0;
      s2_hs_q   <= 1'b0;
      s2_vb_q   <= 1'b0;
      s2_vs_q   <= 1'b0;
      s2_de_q   <= 1'b0;
      frame_q   <= '0;
    end else begin
      ce_q <= ce_pix;
      if (ce_pix) begin
        s1_rgb_q  <= pal_rgb;
        s1_hb_q   <= hblank;
        s1_hs_q   <= hsync;
        s1_vb_q   <= vblank;
        s1_vs_q   <= vsync;
        s1_de_q   <= ~(hblank | vblank);
        s1_dark_q <= dark_d;
        s2_rgb_q  <= s2_rgb_d;
        s2_hb_q   <= s1_hb_q;
        s2_hs_q   <= s1_hs_q;
        s2_vb_q   <= s1_vb_q;
        s2_vs_q   <= s1_vs_q;
        // de travels with its pixel so reset bubbles never report active video.
        s2_de_q   <= s1_de_q;
        if (vsync && !s1_vs_q)
          frame_q <= frame_q + 8'd1;
      end
    end
  end

  assign ce_pix_o = ce_q;
  assign hblank_o = s2_hb_q;
  assign hsync_o  = s2_hs_q;
  assign vblank_o = s2_vb_q;
  assign vsync_o  = s2_vs_q;
  assign de_o     = s2_de_q;
  assign r_o      = s2_rgb_q.r;
  assign g_o      = s2_rgb_q.g;
  assign b_o      = s2_rgb_q.b;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_video_colorizer.sv
// Self-checking bench for video_colorizer: directed literal checks plus randomized run against a pixel-queue model.
module tb_video_colorizer;

  localparam int unsigned SCAN = 1;
`ifdef VIDEO_COLORIZER_SCANLINE_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, ce_pix, scandouble, hblank, hsync, vblank, vsync;
  logic [1:0] mode;
  logic [7:0] video;
  logic       ce_pix_o, hblank_o, hsync_o, vblank_o, vsync_o, de_o;
  logic [7:0] r_o, g_o, b_o, frame_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  video_colorizer #(.SCAN_SHIFT(SCAN)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .scandouble(scandouble), .mode(mode),
    .hblank(hblank), .hsync(hsync), .vblank(vblank), .vsync(vsync), .video(video),
    .ce_pix_o(ce_pix_o), .hblank_o(hblank_o), .hsync_o(hsync_o), .vblank_o(vblank_o),
    .vsync_o(vsync_o), .de_o(de_o), .r_o(r_o), .g_o(g_o), .b_o(b_o), .frame_o(frame_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int r, g, b;
    bit hb, hs, vb, vs, de;
  } px_t;

  px_t m_s1, m_out;
  bit  m_valid = 0;
  bit  m_par, m_phb, m_pvb, m_pvs, m_ce;
  int  m_frame;

  function automatic px_t entry(int md, int v, bit sd, bit hb, bit hs, bit vb, bit vs, bit par);
    px_t p;
    p = '{default: 0};
    case (md)
      0: begin p.r = 0; p.g = v;             p.b = 0; end
      1: begin p.r = v; p.g = (v * 3) / 4;   p.b = 0; end
      2: begin p.r = v; p.g = v;             p.b = v; end
      default: begin p.r = 0; p.g = v;       p.b = v; end
    endcase
    if (SCAN_EN && sd && par) begin
      p.r = p.r / (1 << SCAN);
      p.g = p.g / (1 << SCAN);
      p.b = p.b / (1 << SCAN);
    end
    if (hb || vb) begin p.r = 0; p.g = 0; p.b = 0; end
    p.hb = hb; p.hs = hs; p.vb = vb; p.vs = vs; p.de = !(hb || vb);
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_valid = 1;
      m_s1 = '{default: 0};
      m_out = '{default: 0};
      m_par = 0; m_phb = 0; m_pvb = 0; m_pvs = 0; m_ce = 0; m_frame = 0;
    end else if (m_valid) begin
      m_ce = ce_pix;
      if (ce_pix) begin
        m_out = m_s1;
        m_s1  = entry(int'(mode), int'(video), scandouble, hblank, hsync, vblank, vsync, m_par);
        if (vblank && !m_pvb)      m_par = 0;
        else if (hblank && !m_phb) m_par = !m_par;
        if (vsync && !m_pvs)       m_frame = (m_frame + 1) % 256;
        m_phb = hblank; m_pvb = vblank; m_pvs = vsync;
      end
    end
    #1;
    if (m_valid) begin
      chk("model_ce_pix_o", ce_pix_o, m_ce);
      chk("model_hblank_o", hblank_o, m_out.hb);
      chk("model_hsync_o",  hsync_o,  m_out.hs);
      chk("model_vblank_o", vblank_o, m_out.vb);
      chk("model_vsync_o",  vsync_o,  m_out.vs);
      chk("model_de_o",     de_o,     m_out.de);
      chk("model_r_o",      r_o,      m_out.r);
      chk("model_g_o",      g_o,      m_out.g);
      chk("model_b_o",      b_o,      m_out.b);
      chk("model_frame_o",  frame_o,  m_frame);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hpulse();
    hblank = 1; tick();
    hblank = 0; tick();
  endtask

  initial begin
    logic [7:0] exp_odd;
    exp_odd = SCAN_EN ? 8'h64 : 8'hC8;

    reset = 1; ce_pix = 1; scandouble = 0; mode = 2'd0;
    hblank = 0; hsync = 0; vblank = 0; vsync = 0; video = 8'h00;
    tick(); tick();
    chk("reset_ce_pix_o", ce_pix_o, 0);
    chk("reset_rgb",      {r_o, g_o, b_o}, 0);
    chk("reset_de_frame", {de_o, frame_o}, 0);

    reset = 0; mode = 2'd0; video = 8'h80;
    tick();
    chk("green_latency1_g", g_o, 8'h00);
    tick();
    chk("green_rgb", {r_o, g_o, b_o}, 24'h008000);
    chk("green_de",  de_o, 1);

    mode = 2'd1; video = 8'hFF;
    tick(); tick();
    chk("amber_rgb", {r_o, g_o, b_o}, 24'hFFBF00);

    hblank = 1;
    tick();
    chk("hblank_latency1", hblank_o, 0);
    tick();
    chk("hblank_latency2", hblank_o, 1);
    chk("hblank_rgb",      {r_o, g_o, b_o}, 0);
    chk("hblank_de",       de_o, 0);

    hblank = 0; mode = 2'd2; video = 8'h11;
    tick();
    ce_pix = 0;
    tick();
    chk("ce_low_ce_pix_o", ce_pix_o, 0);
    chk("ce_low_hold_g",   g_o, 8'h00);
    ce_pix = 1;
    tick();
    chk("ce_high_ce_pix_o", ce_pix_o, 1);
    chk("ce_high_r",        r_o, 8'h11);

    scandouble = 1; mode = 2'd2; video = 8'hC8;
    vblank = 1; tick();
    vblank = 0; tick(); tick();
    chk("scan_even0", {r_o, g_o, b_o}, 24'hC8C8C8);
    hpulse(); tick();
    chk("scan_odd1", {r_o, g_o, b_o}, {3{exp_odd}});
    hpulse(); tick();
    chk("scan_even2", {r_o, g_o, b_o}, 24'hC8C8C8);
    hpulse();
    vblank = 1; tick();
    vblank = 0; tick(); tick();
    chk("scan_vblank_even", {r_o, g_o, b_o}, 24'hC8C8C8);
    scandouble = 0;

    video = 8'h5A; hblank = 0;
    tick();
    reset = 1;
    tick();
    chk("midline_reset_rgb",    {r_o, g_o, b_o}, 0);
    chk("midline_reset_timing", {hblank_o, vblank_o, de_o, frame_o}, 0);
    reset = 0;

    for (int unsigned i = 0; i < 256; i++) begin
      vsync = 1; tick();
      vsync = 0; tick();
      if (i == 0)   chk("frame_first", frame_o, 8'd1);
      if (i == 254) chk("frame_255",   frame_o, 8'd255);
    end
    chk("frame_wrap", frame_o, 8'd0);

    for (int unsigned i = 0; i < 4000; i++) begin
      ce_pix = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) mode = 2'($urandom_range(3, 0));
      if ($urandom_range(63, 0) == 0) scandouble = ~scandouble;
      if ($urandom_range(9, 0) == 0)  hblank = ~hblank;
      if ($urandom_range(49, 0) == 0) vblank = ~vblank;
      if ($urandom_range(29, 0) == 0) vsync = ~vsync;
      hsync = ($urandom_range(7, 0) == 0);
      video = 8'($urandom_range(255, 0));
      reset = ($urandom_range(499, 0) == 0);
      tick();
    end
    reset = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
